mem_access: RTL

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_if.sv | 33 +++
 rtl/mem_access.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mem_access_if.sv
// Execute/memory/writeback bundle for mem_access.
// The slave side is the mem_access stage; the master side is its environment.
interface mem_access_if;
    logic        ex_valid;
    logic [31:0] ALU_C;
    logic        ALU_f;
    logic [31:0] rD2;
    logic [3:0]  mem_op;
    logic        mem_stall;
    logic        dram_req;
    logic        dram_we;
    logic [31:0] dram_addr;
    logic [31:0] dram_wdata;
    logic [3:0]  dram_wstrb;
    logic        dram_ack;
    logic [31:0] dram_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic        wb_f;
    logic        misalign;

    modport slave (
        input  ex_valid, ALU_C, ALU_f, rD2, mem_op, dram_ack, dram_rdata,
        output mem_stall, dram_req, dram_we, dram_addr, dram_wdata, dram_wstrb,
               wb_valid, wb_data, wb_f, misalign
    );

    modport master (
        output ex_valid, ALU_C, ALU_f, rD2, mem_op, dram_ack, dram_rdata,
        input  mem_stall, dram_req, dram_we, dram_addr, dram_wdata, dram_wstrb,
               wb_valid, wb_data, wb_f, misalign
    );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: passes ALU results through or runs one DRAM load/store.
// Optional MISALIGN_TRAP_EN: trap misaligned halfword/word accesses instead of aligning them.
module mem_access (
    input  logic         clk,
    input  logic         rst,
    mem_access_if.slave  bus
);
    // state | meaning
    // IDLE  | sample execute inputs; pass-through results complete here
    // BUSY  | DRAM request held until ack
    // DONE  | one-cycle writeback of the memory op
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q;
    logic        dram_req_q, dram_we_q, wb_valid_q, wb_f_q;
    logic [31:0] dram_addr_q, dram_wdata_q, wb_data_q;
    logic [3:0]  dram_wstrb_q;
    logic        ld_q, ld_byte_q, ld_half_q, ld_signed_q;
    logic [1:0]  ld_off_q;

    logic        is_load, is_store, is_byte, is_half, is_word, is_signed, trap;
    logic [1:0]  off_d;
    logic [3:0]  wstrb_d;
    logic [31:0] wdata_d, shifted_d, ld_data_d;

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_byte   = 1'b0;
        is_half   = 1'b0;
        is_word   = 1'b0;
        is_signed = 1'b0;
        case (bus.mem_op)
            4'd1:    begin is_load  = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
            4'd2:    begin is_load  = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
            4'd3:    begin is_load  = 1'b1; is_word = 1'b1; end
            4'd4:    begin is_load  = 1'b1; is_byte = 1'b1; end
            4'd5:    begin is_load  = 1'b1; is_half = 1'b1; end
            4'd8:    begin is_store = 1'b1; is_byte = 1'b1; end
            4'd9:    begin is_store = 1'b1; is_half = 1'b1; end
            4'd10:   begin is_store = 1'b1; is_word = 1'b1; end
            default: ;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic misalign_q;
    assign trap = (is_half & bus.ALU_C[0]) | (is_word & (bus.ALU_C[1:0] != 2'b00));
    assign bus.misalign = misalign_q;
`else
    assign trap = 1'b0;
    assign bus.misalign = 1'b0;
`endif

    // Without the trap, misaligned low bits are simply dropped.
    assign off_d   = is_word ? 2'b00 : (is_half ? {bus.ALU_C[1], 1'b0} : bus.ALU_C[1:0]);
    assign wstrb_d = is_word ? 4'hF : (is_half ? (4'b0011 << off_d) : (4'b0001 << off_d));
    assign wdata_d = is_word ? bus.rD2 : (is_half ? {2{bus.rD2[15:0]}} : {4{bus.rD2[7:0]}});

    assign shifted_d = bus.dram_rdata >> {ld_off_q, 3'b000};
    assign ld_data_d = ld_byte_q ? {{24{ld_signed_q & shifted_d[7]}}, shifted_d[7:0]} :
                       ld_half_q ? {{16{ld_signed_q & shifted_d[15]}}, shifted_d[15:0]} :
                                   shifted_d;

    assign bus.mem_stall  = !rst && ((state_q == BUSY) ||
                            ((state_q == IDLE) && bus.ex_valid && (is_load || is_store)));
    assign bus.dram_req   = dram_req_q;
    assign bus.dram_we    = dram_we_q;
    assign bus.dram_addr  = dram_addr_q;
    assign bus.dram_wdata = dram_wdata_q;
    assign bus.dram_wstrb = dram_wstrb_q;
    assign bus.wb_valid   = wb_valid_q;
    assign bus.wb_data    = wb_data_q;
    assign bus.wb_f       = wb_f_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            dram_req_q   <= 1'b0;
            dram_we_q    <= 1'b0;
            dram_addr_q  <= 32'h0;
            dram_wdata_q <= 32'h0;
            dram_wstrb_q <= 4'h0;
            wb_valid_q   <= 1'b0;
            wb_data_q    <= 32'h0;
            wb_f_q       <= 1'b0;
            ld_q         <= 1'b0;
            ld_byte_q    <= 1'b0;
            ld_half_q    <= 1'b0;
            ld_signed_q  <= 1'b0;
            ld_off_q     <= 2'b00;
`ifdef MISALIGN_TRAP_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            wb_valid_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
            case (state_q)
                IDLE: if (bus.ex_valid) begin
                    wb_data_q <= bus.ALU_C;
                    wb_f_q    <= bus.ALU_f;
                    if (!(is_load || is_store)) begin
                        wb_valid_q <= 1'b1;
                    end else if (trap) begin
                        state_q    <= DONE;
                        wb_valid_q <= 1'b1;
`ifdef MISALIGN_TRAP_EN
                        misalign_q <= 1'b1;
`endif
                    end else begin
                        state_q      <= BUSY;
                        dram_req_q   <= 1'b1;
                        dram_we_q    <= is_store;
                        dram_addr_q  <= {bus.ALU_C[31:2], 2'b00};
                        dram_wdata_q <= is_store ? wdata_d : 32'h0;
                        dram_wstrb_q <= is_store ? wstrb_d : 4'h0;
                        ld_q         <= is_load;
                        ld_byte_q    <= is_byte;
                        ld_half_q    <= is_half;
                        ld_signed_q  <= is_signed;
                        ld_off_q     <= off_d;
                    end
                end
                BUSY: if (bus.dram_ack) begin
                    state_q    <= DONE;
                    dram_req_q <= 1'b0;
                    wb_valid_q <= 1'b1;
                    if (ld_q) wb_data_q <= ld_data_d;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
